// File: rtl/imem_arb_pkg.sv
// Shared types, default sizes and the debug address-check predicate for imem_arbiter.
package imem_arb_pkg;

  typedef enum logic [1:0] {
    RSP_NONE  = 2'd0,
    RSP_FETCH = 2'd1,
    RSP_DEBUG = 2'd2
  } rsp_owner_e;

  localparam int DEF_ADDR_W      = 32;
  localparam int DEF_DATA_W      = 32;
  localparam int DEF_DEPTH_BYTES = 131072;
  localparam int DEF_MAX_DBG_RUN = 4;

  // A debug access is legal only when word-aligned and inside the memory.
  function automatic logic dbg_addr_ok(input logic [63:0] addr, input logic [63:0] depth_bytes);
    return (addr[1:0] == 2'b00) && (addr < depth_bytes);
  endfunction

endpackage

// File: rtl/imem_arb_starve_ctr.sv
// Counts consecutive debug grants while fetch waits; raises force_fetch at the limit.
module imem_arb_starve_ctr
  import imem_arb_pkg::*;
#(
  parameter int MAX_DBG_RUN = DEF_MAX_DBG_RUN
) (
  input  logic clock,
  input  logic reset,
  input  logic f_valid,
  input  logic f_grant,
  input  logic d_grant,
  output logic force_fetch
);

  localparam int CNT_W = $clog2(MAX_DBG_RUN + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_DBG_RUN);

  logic [CNT_W-1:0] cnt_r;

  // Starve counter: cleared when fetch is served or absent, saturates at the limit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_r <= '0;
    end else if (!f_valid || f_grant) begin
      cnt_r <= '0;
    end else if (d_grant && (cnt_r != CNT_MAX)) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign force_fetch = f_valid && (cnt_r == CNT_MAX);

endmodule

// File: rtl/imem_arbiter.sv
// Arbitrates a single-port instruction memory between fetch and debug/loader ports.
// Optional statistics counters are enabled with `define IMEM_ARB_STATS_EN.
module imem_arbiter
  import imem_arb_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int DEPTH_BYTES = DEF_DEPTH_BYTES,
  parameter int MAX_DBG_RUN = DEF_MAX_DBG_RUN,
  localparam int INDEX_W    = $clog2(DEPTH_BYTES) - 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               f_req_valid,
  output logic               f_req_ready,
  input  logic [ADDR_W-1:0]  f_req_addr,
  output logic               f_rsp_valid,
  output logic [DATA_W-1:0]  f_rsp_data,
  input  logic               d_req_valid,
  output logic               d_req_ready,
  input  logic [ADDR_W-1:0]  d_req_addr,
  input  logic               d_req_we,
  input  logic [DATA_W-1:0]  d_req_wdata,
  output logic               d_rsp_valid,
  output logic [DATA_W-1:0]  d_rsp_data,
  output logic               d_rsp_err,
  output logic               mem_en,
  output logic               mem_we,
  output logic [INDEX_W-1:0] mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  input  logic [DATA_W-1:0]  mem_rdata
`ifdef IMEM_ARB_STATS_EN
  ,
  output logic [31:0]        stat_fetch_stall,
  output logic [31:0]        stat_dbg_grants
`endif
);

  rsp_owner_e owner_r, owner_n_s;
  logic       err_r, rd_r;
  logic       f_grant_s, d_grant_s, d_ok_s, force_fetch_s;
  logic       unused_s;

  // Fetch ignores byte-lane and above-memory address bits (wraps).
  assign unused_s = ^{f_req_addr[ADDR_W-1:INDEX_W+2], f_req_addr[1:0]};
  assign d_ok_s   = dbg_addr_ok(64'(d_req_addr), 64'(DEPTH_BYTES));

  imem_arb_starve_ctr #(.MAX_DBG_RUN(MAX_DBG_RUN)) u_starve (
    .clock       (clock),
    .reset       (reset),
    .f_valid     (f_req_valid),
    .f_grant     (f_grant_s),
    .d_grant     (d_grant_s),
    .force_fetch (force_fetch_s)
  );

  // Grant selection; reset suppresses every grant immediately.
  always_comb begin
    f_grant_s = 1'b0;
    d_grant_s = 1'b0;
    if (reset) begin
      f_grant_s = 1'b0;
      d_grant_s = 1'b0;
    end else if (d_req_valid && !force_fetch_s) begin
      d_grant_s = 1'b1;
    end else if (f_req_valid) begin
      f_grant_s = 1'b1;
    end else begin
      f_grant_s = 1'b0;
      d_grant_s = 1'b0;
    end
  end

  assign f_req_ready = f_grant_s;
  assign d_req_ready = d_grant_s;

  // Memory pin drive for the granted requester.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (f_grant_s) begin
      mem_en   = 1'b1;
      mem_addr = f_req_addr[INDEX_W+1:2];
    end else if (d_grant_s && d_ok_s) begin
      mem_en    = 1'b1;
      mem_we    = d_req_we;
      mem_addr  = d_req_addr[INDEX_W+1:2];
      mem_wdata = d_req_we ? d_req_wdata : '0;
    end else begin
      mem_en = 1'b0;
    end
  end

  // Response owner follows this cycle's grant.
  always_comb begin
    owner_n_s = RSP_NONE;
    if (f_grant_s) begin
      owner_n_s = RSP_FETCH;
    end else if (d_grant_s) begin
      owner_n_s = RSP_DEBUG;
    end else begin
      owner_n_s = RSP_NONE;
    end
  end

  // Response state register plus debug error/read flags.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      owner_r <= RSP_NONE;
      err_r   <= 1'b0;
      rd_r    <= 1'b0;
    end else begin
      owner_r <= owner_n_s;
      err_r   <= d_grant_s && !d_ok_s;
      rd_r    <= d_grant_s && d_ok_s && !d_req_we;
    end
  end

  // Response outputs decoded from the registered owner.
  always_comb begin
    f_rsp_valid = 1'b0;
    f_rsp_data  = '0;
    d_rsp_valid = 1'b0;
    d_rsp_data  = '0;
    d_rsp_err   = 1'b0;
    case (owner_r)
      RSP_FETCH: begin
        f_rsp_valid = 1'b1;
        f_rsp_data  = mem_rdata;
      end
      RSP_DEBUG: begin
        d_rsp_valid = 1'b1;
        d_rsp_data  = rd_r ? mem_rdata : '0;
        d_rsp_err   = err_r;
      end
      default: begin
        f_rsp_valid = 1'b0;
        d_rsp_valid = 1'b0;
      end
    endcase
  end

`ifdef IMEM_ARB_STATS_EN
  // Saturating stall and debug-grant counters.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stat_fetch_stall <= 32'd0;
      stat_dbg_grants  <= 32'd0;
    end else begin
      if (f_req_valid && !f_req_ready && (stat_fetch_stall != 32'hFFFF_FFFF)) begin
        stat_fetch_stall <= stat_fetch_stall + 32'd1;
      end else begin
        stat_fetch_stall <= stat_fetch_stall;
      end
      if (d_grant_s && (stat_dbg_grants != 32'hFFFF_FFFF)) begin
        stat_dbg_grants <= stat_dbg_grants + 32'd1;
      end else begin
        stat_dbg_grants <= stat_dbg_grants;
      end
    end
  end
`endif

endmodule

// File: tb/tb_imem_arbiter.sv
// Randomized and directed bench for imem_arbiter against a transaction-level model.
module tb_imem_arbiter;

  localparam int AW = 32, DW = 32, DEPTH = 131072, MAXRUN = 4, WORDS = DEPTH / 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          f_req_valid, f_req_ready, f_rsp_valid;
  logic [AW-1:0] f_req_addr;
  logic [DW-1:0] f_rsp_data;
  logic          d_req_valid, d_req_ready, d_req_we, d_rsp_valid, d_rsp_err;
  logic [AW-1:0] d_req_addr;
  logic [DW-1:0] d_req_wdata, d_rsp_data;
  logic          mem_en, mem_we;
  logic [14:0]   mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
`ifdef IMEM_ARB_STATS_EN
  logic [31:0]   stat_fetch_stall, stat_dbg_grants;
`endif

  always #5 clock = ~clock;

  imem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DEPTH_BYTES(DEPTH), .MAX_DBG_RUN(MAXRUN)) dut (
    .clock(clock), .reset(reset),
    .f_req_valid(f_req_valid), .f_req_ready(f_req_ready), .f_req_addr(f_req_addr),
    .f_rsp_valid(f_rsp_valid), .f_rsp_data(f_rsp_data),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
    .d_req_we(d_req_we), .d_req_wdata(d_req_wdata),
    .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data), .d_rsp_err(d_rsp_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
`ifdef IMEM_ARB_STATS_EN
    , .stat_fetch_stall(stat_fetch_stall), .stat_dbg_grants(stat_dbg_grants)
`endif
  );

  // Environment memory: single-port, write-first, one-cycle read latency.
  logic [DW-1:0] env_mem [WORDS];
  always @(posedge clock) begin
    if (mem_en) begin
      if (mem_we) begin
        env_mem[mem_addr] <= mem_wdata;
        mem_rdata         <= mem_wdata;
      end else begin
        mem_rdata <= env_mem[mem_addr];
      end
    end
  end

  // Reference model state.
  logic [DW-1:0] ref_mem [WORDS];
  bit            pend_f, pend_d, pend_de;
  logic [DW-1:0] pend_fd, pend_dd;
  int            run, fwait, m_stall, m_dgr;
  int            vectors = 0, miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input bit fv, input logic [31:0] fa, input bit dv,
                      input logic [31:0] da, input bit dwe, input logic [31:0] dwd);
    bit fg, dg, dok, ewe;
    int fidx, didx;
    @(posedge clock);
    #1;
    f_req_valid = fv; f_req_addr = fa;
    d_req_valid = dv; d_req_addr = da; d_req_we = dwe; d_req_wdata = dwd;
    #3;
    check("f_rsp_valid", 32'(f_rsp_valid), 32'(pend_f));
    check("f_rsp_data",  f_rsp_data, pend_f ? pend_fd : 32'd0);
    check("d_rsp_valid", 32'(d_rsp_valid), 32'(pend_d));
    check("d_rsp_data",  d_rsp_data, pend_d ? pend_dd : 32'd0);
    check("d_rsp_err",   32'(d_rsp_err), 32'(pend_d && pend_de));
    // Fetch is served when debug is idle or after MAXRUN debug grants in a row.
    fg   = fv && (!dv || run == MAXRUN);
    dg   = dv && !fg;
    dok  = (da % 32'd4 == 32'd0) && (da < 32'(DEPTH));
    ewe  = dg && dok && dwe;
    fidx = int'((fa / 32'd4) % 32'(WORDS));
    didx = int'((da / 32'd4) % 32'(WORDS));
    check("f_req_ready", 32'(f_req_ready), 32'(fg));
    check("d_req_ready", 32'(d_req_ready), 32'(dg));
    check("mem_en",      32'(mem_en), 32'(fg || (dg && dok)));
    check("mem_we",      32'(mem_we), 32'(ewe));
    check("mem_wdata",   mem_wdata, ewe ? dwd : 32'd0);
    if (fg) check("mem_addr_f", 32'(mem_addr), 32'(fidx));
    else if (dg && dok) check("mem_addr_d", 32'(mem_addr), 32'(didx));
    // Advance the model to the next cycle.
    pend_f  = fg;
    pend_fd = ref_mem[fidx];
    pend_d  = dg;
    pend_de = dg && !dok;
    pend_dd = (dg && dok && !dwe) ? ref_mem[didx] : 32'd0;
    if (ewe) ref_mem[didx] = dwd;
    run   = (fv && dg) ? run + 1 : 0;
    fwait = (fv && !fg) ? fwait + 1 : 0;
    check("fwait_bound", 32'(fwait <= MAXRUN), 32'd1);
    if (fv && !fg) m_stall++;
    if (dg) m_dgr++;
  endtask

  task automatic model_reset();
    pend_f = 1'b0; pend_d = 1'b0; pend_de = 1'b0; pend_fd = '0; pend_dd = '0;
    run = 0; fwait = 0; m_stall = 0; m_dgr = 0;
  endtask

  initial begin
    logic [31:0] fa, da;
    int sel;
    reset = 1'b1;
    f_req_valid = 1'b0; f_req_addr = '0;
    d_req_valid = 1'b0; d_req_addr = '0; d_req_we = 1'b0; d_req_wdata = '0;
    model_reset();
    repeat (2) @(posedge clock);
    #4;
    check("rst_f_rsp_valid", 32'(f_rsp_valid), 32'd0);
    check("rst_d_rsp_valid", 32'(d_rsp_valid), 32'd0);
    check("rst_d_rsp_err",   32'(d_rsp_err), 32'd0);
    check("rst_mem_en",      32'(mem_en), 32'd0);
    check("rst_mem_wdata",   mem_wdata, 32'd0);
    f_req_valid = 1'b1; d_req_valid = 1'b1; d_req_we = 1'b1; d_req_wdata = 32'hFFFF_FFFF;
    #1;
    check("rst_f_ready",     32'(f_req_ready), 32'd0);
    check("rst_d_ready",     32'(d_req_ready), 32'd0);
    check("rst_mem_we",      32'(mem_we), 32'd0);
    f_req_valid = 1'b0; d_req_valid = 1'b0; d_req_we = 1'b0; d_req_wdata = '0;
    reset = 1'b0;

    // Preload words 0..31 through the debug port.
    for (int i = 0; i < 32; i++) begin
      step(1'b0, 32'd0, 1'b1, 32'(i * 4), 1'b1,
           (i == 0) ? 32'h11 : (i == 1) ? 32'h22 : (i == 2) ? 32'h33 : $urandom);
    end
    // Fetch-only stream.
    step(1'b1, 32'h0, 1'b0, 32'd0, 1'b0, 32'd0);
    step(1'b1, 32'h4, 1'b0, 32'd0, 1'b0, 32'd0);
    step(1'b1, 32'h8, 1'b0, 32'd0, 1'b0, 32'd0);
    step(1'b0, 32'h0, 1'b0, 32'd0, 1'b0, 32'd0);
    // Debug write then read-after-write.
    step(1'b0, 32'h0, 1'b1, 32'h100, 1'b1, 32'hDEADBEEF);
    step(1'b0, 32'h0, 1'b1, 32'h100, 1'b0, 32'd0);
    // Misaligned and out-of-range debug reads.
    step(1'b0, 32'h0, 1'b1, 32'h102, 1'b0, 32'd0);
    step(1'b0, 32'h0, 1'b1, 32'h20000, 1'b0, 32'd0);
    // Fetch address wrap.
    step(1'b1, 32'h20004, 1'b0, 32'd0, 1'b0, 32'd0);
    step(1'b0, 32'h0, 1'b0, 32'd0, 1'b0, 32'd0);
    // Continuous contention.
    for (int i = 0; i < 15; i++) step(1'b1, 32'(i * 4 % 128), 1'b1, 32'(i * 8 % 128), 1'b0, 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      fa  = (32'($urandom_range(0, 31)) << 2) | (32'($urandom_range(0, 7)) << 17) | 32'($urandom_range(0, 3));
      sel = int'($urandom_range(0, 7));
      if (sel == 0)      da = (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(1, 3));
      else if (sel == 1) da = 32'h20000 + (32'($urandom_range(0, 255)) << 2);
      else               da = 32'($urandom_range(0, 31)) << 2;
      step($urandom_range(0, 3) != 0, fa, $urandom_range(0, 1) == 1, da,
           $urandom_range(0, 1) == 1, $urandom);
    end

`ifdef IMEM_ARB_STATS_EN
    step(1'b0, 32'h0, 1'b0, 32'd0, 1'b0, 32'd0);
    check("stat_fetch_stall", stat_fetch_stall, 32'(m_stall));
    check("stat_dbg_grants",  stat_dbg_grants,  32'(m_dgr));
`endif

    // Reset between a fetch grant and its response drops the response.
    step(1'b1, 32'h40, 1'b0, 32'd0, 1'b0, 32'd0);
    #2;
    reset = 1'b1;
    #1;
    check("rstmid_f_ready",  32'(f_req_ready), 32'd0);
    check("rstmid_mem_en",   32'(mem_en), 32'd0);
    check("rstmid_f_rsp",    32'(f_rsp_valid), 32'd0);
    check("rstmid_d_rsp",    32'(d_rsp_valid), 32'd0);
    f_req_valid = 1'b0;
    @(posedge clock);
    #4;
    check("rstdrop_f_rsp",   32'(f_rsp_valid), 32'd0);
    check("rstdrop_f_data",  f_rsp_data, 32'd0);
    reset = 1'b0;
    model_reset();
    step(1'b0, 32'h0, 1'b0, 32'd0, 1'b0, 32'd0);
    step(1'b1, 32'h8, 1'b1, 32'h4, 1'b0, 32'd0);
    step(1'b0, 32'h0, 1'b0, 32'd0, 1'b0, 32'd0);
    step(1'b0, 32'h0, 1'b0, 32'd0, 1'b0, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
